pe_lane_tile: RTL

Multi-lane, parametrised successor to the single-lane PE wrapper.
- NUM_LANES signed MAC lanes share one broadcast horizontal operand. Each lane takes its own vertical operand, either from the v-bus or from the upstream (top) tile.
- Accumulates a programmed number of beats under valid/ready flow control, then drains the formatted lane results serially on the bottom port.
- Sits in a PE column. bot_* of one tile feeds the drain path of the next tile, or the column collector.

---
 rtl/pe_lane_pkg.sv | 38 +++
 rtl/pe_lane_tile_mac.sv | 61 ++++++
 rtl/pe_lane_tile.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/pe_lane_pkg.sv
// Shared types and helpers for the pe_lane_tile MAC column tile.
// Build with PE_LANE_SAT_EN defined for saturating accumulate and output formatting.
package pe_lane_pkg;

  typedef enum logic [1:0] {
    MODE_MAC_V     = 2'd0,
    MODE_MAC_TOP   = 2'd1,
    MODE_CLR_MAC_V = 2'd2,
    MODE_FLUSH     = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_WAIT,
    ST_DRAIN,
    ST_DONE
  } state_e;

  localparam int WAIT_CYCLES = 2;

  // Caller sign-extends acc to 64 bits and keeps the low `width` bits of the result.
  function automatic logic [63:0] fmt_out(input logic signed [63:0] acc,
                                          input int shift, input int width);
    logic signed [63:0] s;
    s = acc >>> shift;
`ifdef PE_LANE_SAT_EN
    if (s > (64'sd1 <<< (width - 1)) - 64'sd1)
      s = (64'sd1 <<< (width - 1)) - 64'sd1;
    else if (s < -(64'sd1 <<< (width - 1)))
      s = -(64'sd1 <<< (width - 1));
    return s;
`else
    return s & ((64'sd1 <<< width) - 64'sd1);
`endif
  endfunction

endpackage

// File: rtl/pe_lane_tile_mac.sv
// One MAC lane: registered signed product (stage 2) and accumulator (stage 3).
// acc_nxt_o exposes the accumulator's next value so the drain can load it on the update edge.
module pe_lane_mac #(
  parameter int WIDTH_DATA = 16,
  parameter int WIDTH_ACC  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic                  valid_i,
  input  logic [WIDTH_DATA-1:0] a_i,
  input  logic [WIDTH_DATA-1:0] b_i,
  output logic [WIDTH_ACC-1:0]  acc_nxt_o
);

  logic signed [2*WIDTH_DATA-1:0] mul;
  logic [WIDTH_ACC-1:0] prod_q, acc_q, acc_d;
  logic                 v2_q;

  assign mul = $signed(a_i) * $signed(b_i);

`ifdef PE_LANE_SAT_EN
  logic [WIDTH_ACC:0] sum;
  assign sum = {acc_q[WIDTH_ACC-1], acc_q} + {prod_q[WIDTH_ACC-1], prod_q};
`else
  logic [WIDTH_ACC-1:0] sum;
  assign sum = acc_q + prod_q;
`endif

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (v2_q) begin
`ifdef PE_LANE_SAT_EN
      // Differing top two bits of the extended sum means signed overflow.
      if (sum[WIDTH_ACC] != sum[WIDTH_ACC-1])
        acc_d = sum[WIDTH_ACC] ? {1'b1, {(WIDTH_ACC-1){1'b0}}} : {1'b0, {(WIDTH_ACC-1){1'b1}}};
      else
        acc_d = sum[WIDTH_ACC-1:0];
`else
      acc_d = sum;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q <= '0;
      v2_q   <= 1'b0;
      acc_q  <= '0;
    end else begin
      prod_q <= WIDTH_ACC'(mul);
      v2_q   <= valid_i;
      acc_q  <= acc_d;
    end
  end

  assign acc_nxt_o = acc_d;

endmodule

// File: rtl/pe_lane_tile.sv
// Multi-lane signed MAC tile: accumulate k_len broadcast beats, then drain lanes on bot_*.
// PE_LANE_SAT_EN selects saturating arithmetic in the lanes and output formatter.
module pe_lane_tile
  import pe_lane_pkg::*;
#(
  parameter int WIDTH_DATA = 16,
  parameter int WIDTH_ACC  = 32,
  parameter int NUM_LANES  = 4,
  parameter int CNT_WIDTH  = 8,
  parameter int OUT_SHIFT  = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start_i,
  input  logic [1:0]                      mode_i,
  input  logic [CNT_WIDTH-1:0]            k_len_i,
  input  logic                            in_valid_i,
  output logic                            in_ready_o,
  input  logic [NUM_LANES*WIDTH_DATA-1:0] v_bus_data_i,
  input  logic [NUM_LANES*WIDTH_DATA-1:0] top_data_i,
  input  logic [WIDTH_DATA-1:0]           h_bus_data_i,
  output logic                            bot_valid_o,
  input  logic                            bot_ready_i,
  output logic [WIDTH_DATA-1:0]           bot_data_o,
  output logic [$clog2(NUM_LANES)-1:0]    bot_lane_o,
  output logic                            busy_o,
  output logic                            done_o
);

  localparam int LW = $clog2(NUM_LANES);
  localparam logic [LW-1:0] LAST = LW'(NUM_LANES - 1);

  state_e                        state_q, state_d;
  mode_e                         mode_q, mode_d;
  logic [CNT_WIDTH-1:0]          rem_q, rem_d;
  logic [1:0]                    wait_q, wait_d;
  logic [NUM_LANES*WIDTH_DATA-1:0] a_q;
  logic [WIDTH_DATA-1:0]         b_q;
  logic                          v1_q;
  logic                          bot_valid_q, bot_valid_d;
  logic [WIDTH_DATA-1:0]         bot_data_q, bot_data_d;
  logic [LW-1:0]                 bot_lane_q, bot_lane_d, lane_sel;
  logic                          accept, clr_acc, load_sel;
  logic [WIDTH_ACC-1:0]          acc_nxt [NUM_LANES];

  assign in_ready_o = (state_q == ST_ACCUM) && (rem_q != '0);
  assign accept     = in_valid_i && in_ready_o;
  assign clr_acc    = (state_q == ST_IDLE) && start_i && (mode_i == MODE_CLR_MAC_V);

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    rem_d       = rem_q;
    wait_d      = wait_q;
    bot_valid_d = bot_valid_q;
    bot_lane_d  = bot_lane_q;
    lane_sel    = '0;
    load_sel    = 1'b0;
    case (state_q)
      ST_IDLE: if (start_i) begin
        mode_d = mode_e'(mode_i);
        rem_d  = k_len_i;
        if (mode_i == MODE_FLUSH || k_len_i == '0) begin
          state_d  = ST_DRAIN;
          load_sel = 1'b1;
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: if (accept) begin
        rem_d = rem_q - 1'b1;
        if (rem_q == CNT_WIDTH'(1)) begin
          state_d = ST_WAIT;
          wait_d  = 2'(WAIT_CYCLES - 1);
        end
      end
      ST_WAIT: begin
        if (wait_q == '0) begin
          state_d  = ST_DRAIN;
          load_sel = 1'b1;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      ST_DRAIN: if (bot_ready_i) begin
        if (bot_lane_q == LAST) begin
          state_d     = ST_DONE;
          bot_valid_d = 1'b0;
        end else begin
          lane_sel = bot_lane_q + 1'b1;
          load_sel = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (load_sel) begin
      bot_valid_d = 1'b1;
      bot_lane_d  = lane_sel;
    end
  end

  // Drain loads read next-state accumulators so the last beat lands on the WAIT->DRAIN edge.
  always_comb begin
    bot_data_d = bot_data_q;
    if (load_sel)
      bot_data_d = WIDTH_DATA'(fmt_out(64'($signed(acc_nxt[lane_sel])), OUT_SHIFT, WIDTH_DATA));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_MAC_V;
      rem_q       <= '0;
      wait_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      v1_q        <= 1'b0;
      bot_valid_q <= 1'b0;
      bot_data_q  <= '0;
      bot_lane_q  <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      rem_q       <= rem_d;
      wait_q      <= wait_d;
      a_q         <= (mode_q == MODE_MAC_TOP) ? top_data_i : v_bus_data_i;
      b_q         <= h_bus_data_i;
      v1_q        <= accept;
      bot_valid_q <= bot_valid_d;
      bot_data_q  <= bot_data_d;
      bot_lane_q  <= bot_lane_d;
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    pe_lane_mac #(
      .WIDTH_DATA(WIDTH_DATA),
      .WIDTH_ACC (WIDTH_ACC)
    ) u_mac (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (clr_acc),
      .valid_i  (v1_q),
      .a_i      (a_q[g*WIDTH_DATA +: WIDTH_DATA]),
      .b_i      (b_q),
      .acc_nxt_o(acc_nxt[g])
    );
  end

  assign bot_valid_o = bot_valid_q;
  assign bot_data_o  = bot_data_q;
  assign bot_lane_o  = bot_lane_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = (state_q == ST_DONE);

endmodule
